// File: rtl/link_frame_scheduler.sv
// Round-robin two-channel frame sender for a dual-rail, four-phase return-to-zero link.
// Define LINK_FRAME_PARITY_EN to insert a parity bit (ch ^ cmd) after the command bit.
module link_frame_scheduler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned TO_W        = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic ch1_req,
  input  logic ch1_up,
  input  logic ch2_req,
  input  logic ch2_up,
  input  logic ack,
  output logic ch1_grant,
  output logic ch2_grant,
  output logic bit0_out,
  output logic bit1_out,
  output logic busy,
  output logic frame_done,
  output logic err
);

`ifdef LINK_FRAME_PARITY_EN
  localparam int unsigned FRAME_LEN = 7;
`else
  localparam int unsigned FRAME_LEN = 6;
`endif
  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic             TO_EN    = 1'(ACK_TIMEOUT != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT0 = 3'd1;
  localparam logic [2:0] S_DRIVE = 3'd2;
  localparam logic [2:0] S_RTZ   = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_ch, r_cmd, r_last_grant;
  logic                   r_g1, r_g2, r_b0, r_b1, r_busy, r_done, r_err;

  logic [2:0]             w_state_nx;
  logic [IDX_W-1:0]       w_idx_nx;
  logic [TO_W-1:0]        w_to_nx;
  logic                   w_ch_nx, w_cmd_nx, w_last_nx;
  logic                   w_g1_nx, w_g2_nx, w_b0_nx, w_b1_nx, w_busy_nx, w_done_nx, w_err_nx;
  logic                   w_ack_s, w_to_hit, w_win, w_rail;

  // Value of frame bit idx for the captured channel and command.
  function automatic logic frame_bit(input logic [IDX_W-1:0] idx, input logic ch, input logic cmd);
    logic b;
    b = 1'b0;
    case (idx)
      3'd0: b = 1'b1;
      3'd1: b = 1'b0;
      3'd2: b = ch;
      3'd3: b = cmd;
`ifdef LINK_FRAME_PARITY_EN
      3'd4: b = ch ^ cmd;
      3'd5: b = 1'b0;
      3'd6: b = 1'b1;
`else
      3'd4: b = 1'b0;
      3'd5: b = 1'b1;
`endif
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  assign w_ack_s  = r_sync[SYNC_STAGES-1];
  assign w_to_hit = TO_EN && (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_to_nx    = r_to_cnt;
    w_ch_nx    = r_ch;
    w_cmd_nx   = r_cmd;
    w_last_nx  = r_last_grant;
    w_g1_nx    = 1'b0;
    w_g2_nx    = 1'b0;
    w_b0_nx    = r_b0;
    w_b1_nx    = r_b1;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_win      = 1'b0;
    w_rail     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ch1_req || ch2_req) begin
          // On a tie the channel that was not granted last wins.
          w_win      = (ch1_req && ch2_req) ? ~r_last_grant : ch2_req;
          w_ch_nx    = w_win;
          w_cmd_nx   = w_win ? ch2_up : ch1_up;
          w_last_nx  = w_win;
          w_g1_nx    = ~w_win;
          w_g2_nx    = w_win;
          w_busy_nx  = 1'b1;
          w_idx_nx   = '0;
          w_to_nx    = '0;
          w_state_nx = S_WAIT0;
        end
      end
      S_WAIT0: begin
        if (!w_ack_s) begin
          w_rail     = frame_bit(r_idx, r_ch, r_cmd);
          w_b1_nx    = w_rail;
          w_b0_nx    = ~w_rail;
          w_to_nx    = '0;
          w_state_nx = S_DRIVE;
        end else if (w_to_hit) begin
          w_b0_nx    = 1'b0;
          w_b1_nx    = 1'b0;
          w_to_nx    = '0;
          w_state_nx = S_ABORT;
        end else begin
          w_to_nx = r_to_cnt + TO_W'(1);
        end
      end
      S_DRIVE: begin
        if (w_ack_s || w_to_hit) begin
          w_b0_nx    = 1'b0;
          w_b1_nx    = 1'b0;
          w_to_nx    = '0;
          w_state_nx = w_ack_s ? S_RTZ : S_ABORT;
        end else begin
          w_to_nx = r_to_cnt + TO_W'(1);
        end
      end
      S_RTZ: begin
        if (!w_ack_s) begin
          w_to_nx = '0;
          if (r_idx == LAST_IDX) begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_idx_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            // Next bit goes straight onto the link without revisiting WAIT0.
            w_idx_nx   = r_idx + IDX_W'(1);
            w_rail     = frame_bit(r_idx + IDX_W'(1), r_ch, r_cmd);
            w_b1_nx    = w_rail;
            w_b0_nx    = ~w_rail;
            w_state_nx = S_DRIVE;
          end
        end else if (w_to_hit) begin
          w_to_nx    = '0;
          w_state_nx = S_ABORT;
        end else begin
          w_to_nx = r_to_cnt + TO_W'(1);
        end
      end
      S_ABORT: begin
        w_b0_nx = 1'b0;
        w_b1_nx = 1'b0;
        if (!w_ack_s) begin
          w_err_nx   = 1'b1;
          w_busy_nx  = 1'b0;
          w_idx_nx   = '0;
          w_to_nx    = '0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_b0_nx    = 1'b0;
        w_b1_nx    = 1'b0;
        w_busy_nx  = 1'b0;
        w_idx_nx   = '0;
        w_to_nx    = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Ack synchronizer and all state; reset clears the rails without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync       <= '0;
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_to_cnt     <= '0;
      r_ch         <= 1'b0;
      r_cmd        <= 1'b0;
      r_last_grant <= 1'b1;
      r_g1         <= 1'b0;
      r_g2         <= 1'b0;
      r_b0         <= 1'b0;
      r_b1         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], ack};
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_to_cnt     <= w_to_nx;
      r_ch         <= w_ch_nx;
      r_cmd        <= w_cmd_nx;
      r_last_grant <= w_last_nx;
      r_g1         <= w_g1_nx;
      r_g2         <= w_g2_nx;
      r_b0         <= w_b0_nx;
      r_b1         <= w_b1_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_err        <= w_err_nx;
    end
  end

  assign ch1_grant  = r_g1;
  assign ch2_grant  = r_g2;
  assign bit0_out   = r_b0;
  assign bit1_out   = r_b1;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_link_frame_scheduler.sv
// Bench for link_frame_scheduler: scripted and random requests, behavioural receiver,
// expected frames queued at issue time and matched by a monitor on grant/done/err.
module tb_link_frame_scheduler;
  localparam int SYNC = 2;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ch1_req = 1'b0, ch1_up = 1'b0, ch2_req = 1'b0, ch2_up = 1'b0;
  logic ack = 1'b0;
  logic ch1_grant, ch2_grant, bit0_out, bit1_out, busy, frame_done, err;

  always #5 clk = ~clk;

  link_frame_scheduler #(.SYNC_STAGES(SYNC), .ACK_TIMEOUT(TO), .TO_W(10)) dut (
    .clk(clk), .reset(reset),
    .ch1_req(ch1_req), .ch1_up(ch1_up), .ch2_req(ch2_req), .ch2_up(ch2_up),
    .ack(ack),
    .ch1_grant(ch1_grant), .ch2_grant(ch2_grant),
    .bit0_out(bit0_out), .bit1_out(bit1_out),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  typedef struct {
    bit ch;
    bit abort;
    bit b[7];
    int len;
  } exp_t;

  exp_t exp_q[$];
  bit   rx_bits[$];
  int   errors = 0, checks = 0;
  bit   rx_en = 1'b1;
  bit   ack_idle_val = 1'b0;
  int   rx_cnt = 0, rx_lim = 2;
  int   hi_cnt = 0, grant_cnt = 0;
  bit   both_seen = 1'b0, rise_bad = 1'b0;
  logic prev_b0 = 1'b0, prev_b1 = 1'b0;
  bit   last_ch = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame contents straight from the link framing rules.
  function automatic exp_t mk(input bit ch, input bit cmd, input bit ab);
    exp_t e;
    bit s[$];
    s = '{1'b1, 1'b0, ch, cmd};
`ifdef LINK_FRAME_PARITY_EN
    s.push_back(ch ^ cmd);
`endif
    s.push_back(1'b0);
    s.push_back(1'b1);
    e.ch = ch;
    e.abort = ab;
    e.len = s.size();
    foreach (e.b[i]) e.b[i] = (i < s.size()) ? s[i] : 1'b0;
    return e;
  endfunction

  // Receiver (four-phase, random 1..4 cycle response) plus output monitor.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      ack = 1'b0;
      rx_cnt = 0;
      prev_b0 = 1'b0;
      prev_b1 = 1'b0;
    end else begin
      if (bit0_out && bit1_out) both_seen = 1'b1;
      if (((bit0_out && !prev_b0) || (bit1_out && !prev_b1)) && ack) rise_bad = 1'b1;
      prev_b0 = bit0_out;
      prev_b1 = bit1_out;
      if (bit0_out || bit1_out) hi_cnt++;
      if (rx_en) begin
        if ((bit0_out | bit1_out) != ack) begin
          rx_cnt++;
          if (rx_cnt >= rx_lim) begin
            ack = bit0_out | bit1_out;
            if (ack) rx_bits.push_back(bit1_out);
            rx_cnt = 0;
            rx_lim = $urandom_range(4, 1);
          end
        end else begin
          rx_cnt = 0;
        end
      end else begin
        ack = ack_idle_val;
        rx_cnt = 0;
      end

      if (ch1_grant || ch2_grant) begin
        grant_cnt++;
        hi_cnt = 0;
        chk("grant_onehot", int'(ch1_grant & ch2_grant), 0);
        chk("busy_at_grant", int'(busy), 1);
        if (exp_q.size() == 0) chk("grant_unexpected", 1, 0);
        else chk("grant_ch", int'(ch2_grant), int'(exp_q[0].ch));
      end
      if (frame_done || err) begin
        if (exp_q.size() == 0) begin
          chk("output_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("abort_kind", int'(err), int'(e.abort));
          chk("busy_clear", int'(busy), 0);
          if (err) begin
            chk("timeout_rail_cycles", hi_cnt, TO);
          end else begin
            chk("frame_len", rx_bits.size(), e.len);
            for (int i = 0; i < e.len && i < rx_bits.size(); i++)
              chk($sformatf("frame_bit%0d", i), int'(rx_bits[i]), int'(e.b[i]));
          end
        end
        rx_bits.delete();
      end
    end
  end

  task automatic wait_grants(input int target);
    int n = 0;
    while (grant_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (grant_cnt < target) chk("grant_timeout", grant_cnt, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic single(input bit ch, input bit up);
    int g;
    exp_q.push_back(mk(ch, up, !rx_en));
    last_ch = ch;
    @(negedge clk);
    g = grant_cnt;
    if (ch) begin ch2_req = 1'b1; ch2_up = up; end
    else    begin ch1_req = 1'b1; ch1_up = up; end
    wait_grants(g + 1);
    ch1_req = 1'b0;
    ch2_req = 1'b0;
    wait_idle();
  endtask

  task automatic both_hold(input int n, input bit u1, input bit u2);
    int g;
    bit w;
    for (int i = 0; i < n; i++) begin
      w = ~last_ch;
      exp_q.push_back(mk(w, w ? u2 : u1, 1'b0));
      last_ch = w;
    end
    @(negedge clk);
    g = grant_cnt;
    ch1_req = 1'b1; ch1_up = u1;
    ch2_req = 1'b1; ch2_up = u2;
    wait_grants(g + n);
    ch1_req = 1'b0;
    ch2_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    int k;
    int g;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({ch1_grant, ch2_grant, bit0_out, bit1_out, busy, frame_done, err}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Tie from reset: Ch1, Ch2, Ch1.
    both_hold(3, 1'b1, 1'b0);
    single(1'b0, 1'b1);

    // Receiver silent: timeout abort, then normal service.
    rx_en = 1'b0;
    ack_idle_val = 1'b0;
    single(1'b0, 1'b0);
    rx_en = 1'b1;
    single(1'b1, 1'b1);

    // Ack stuck high at grant time.
    rx_en = 1'b0;
    ack_idle_val = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
    last_ch = 1'b1;
    g = grant_cnt;
    ch2_req = 1'b1;
    ch2_up = 1'b0;
    wait_grants(g + 1);
    ch2_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rails_low_in_wait0", int'({bit0_out, bit1_out}), 0);
    @(posedge clk);
    #2;
    ack_idle_val = 1'b0;
    @(negedge clk);
    #1;
    rx_en = 1'b1;
    k = 0;
    while (!(bit0_out || bit1_out) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rise_after_ack_fall", k, SYNC + 1);
    wait_idle();

    for (int it = 0; it < 10; it++) begin
      int sel;
      bit u1, u2;
      sel = $urandom_range(2, 0);
      u1 = 1'($urandom_range(1, 0));
      u2 = 1'($urandom_range(1, 0));
      case (sel)
        0: single(1'b0, u1);
        1: single(1'b1, u2);
        default: both_hold($urandom_range(3, 2), u1, u2);
      endcase
    end

    // Reset while bit 3 (cmd=1) is on the link.
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
    last_ch = 1'b0;
    g = grant_cnt;
    ch1_req = 1'b1;
    ch1_up = 1'b1;
    wait_grants(g + 1);
    ch1_req = 1'b0;
    k = 0;
    while (!(rx_bits.size() == 3 && !ack && (bit0_out || bit1_out)) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("bit3_on_link", int'(bit1_out), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rail_clear", int'({bit0_out, bit1_out}), 0);
    exp_q.delete();
    rx_bits.delete();
    last_ch = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", int'({ch1_grant, ch2_grant, bit0_out, bit1_out, busy, frame_done, err}), 0);
    both_hold(1, 1'b0, 1'b1);

    chk("queue_drained", exp_q.size(), 0);
    chk("both_rails_high", int'(both_seen), 0);
    chk("rail_rise_under_ack", int'(rise_bad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
